// File: rtl/verify_checksum_if.sv
// Byte-stream input and checksum result bundle for verify_checksum.
// The source drives data/valid/start; the checker returns the registered verdict.
interface verify_checksum_if;
  logic [7:0] data_i;
  logic       valid_i;
  logic       start_i;
  logic       done_o;
  logic       ok_o;
  logic       fmt_err_o;
  logic [7:0] computed_o;
  logic [7:0] received_o;
  logic       busy_o;

  modport master (
    output data_i, valid_i, start_i,
    input  done_o, ok_o, fmt_err_o, computed_o, received_o, busy_o
  );

  modport slave (
    input  data_i, valid_i, start_i,
    output done_o, ok_o, fmt_err_o, computed_o, received_o, busy_o
  );
endinterface

// File: rtl/verify_checksum.sv
// Receive-side FIX checksum verifier: sums body bytes mod 256 up to the SOH before "10=",
// parses the three-digit trailer and its closing SOH, and pulses done with the verdict.
module verify_checksum #(
  parameter logic [7:0] SOH_CHAR = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  verify_checksum_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, BODY, SOH_SEEN, TAG1, TAG10, DIG0, DIG1, DIG2, TERM, REPORT
  } state_t;

  state_t     state;
  logic [7:0] sum;
  logic [7:0] snap;
  logic [9:0] acc;

  logic [7:0] din;
  logic       is_soh;
  logic       is_digit;
  logic [7:0] dval;
  logic [7:0] sum_next;
  logic [9:0] acc_next;
  logic       enter_report;
  logic       rep_err;
  logic       rep_bad;

  function automatic logic is_dec(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  assign din      = bus.data_i;
  assign is_soh   = (din == SOH_CHAR);
  assign is_digit = is_dec(din);
  assign dval     = din - 8'h30;
  assign sum_next = sum + din;
  assign acc_next = (acc * 10'd10) + {2'd0, dval};

  // Trailer termination is decided combinationally so the verdict registers on the same edge.
  always_comb begin
    enter_report = 1'b0;
    rep_err      = 1'b0;
    if (bus.valid_i && !bus.start_i) begin
      case (state)
        DIG0, DIG1, DIG2: begin
          if (!is_digit) begin
            enter_report = 1'b1;
            rep_err      = 1'b1;
          end
        end
        TERM: begin
          enter_report = 1'b1;
          rep_err      = !is_soh;
        end
        default: ;
      endcase
    end
  end

  assign rep_bad    = rep_err || (acc > 10'd255);
  assign bus.busy_o = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      sum            <= 8'd0;
      snap           <= 8'd0;
      acc            <= 10'd0;
      bus.done_o     <= 1'b0;
      bus.ok_o       <= 1'b0;
      bus.fmt_err_o  <= 1'b0;
      bus.computed_o <= 8'd0;
      bus.received_o <= 8'd0;
    end else begin
      bus.done_o <= 1'b0;
      if (state == REPORT) state <= IDLE;

      if (bus.valid_i) begin
        if (bus.start_i) begin
          sum <= din;
          acc <= 10'd0;
          if (is_soh) begin
            snap  <= din;
            state <= SOH_SEEN;
          end else begin
            state <= BODY;
          end
        end else begin
          case (state)
            BODY, SOH_SEEN, TAG1, TAG10: begin
              sum <= sum_next;
              if (is_soh) begin
                snap  <= sum_next;
                state <= SOH_SEEN;
              end else if (state == SOH_SEEN && din == 8'h31) begin
                state <= TAG1;
              end else if (state == TAG1 && din == 8'h30) begin
                state <= TAG10;
              end else if (state == TAG10 && din == 8'h3D) begin
                acc   <= 10'd0;
                state <= DIG0;
              end else begin
                state <= BODY;
              end
            end
            DIG0, DIG1, DIG2: begin
              if (is_digit) begin
                acc <= acc_next;
                case (state)
                  DIG0:    state <= DIG1;
                  DIG1:    state <= DIG2;
                  default: state <= TERM;
                endcase
              end else begin
                state <= REPORT;
              end
            end
            TERM:    state <= REPORT;
            default: ;
          endcase
        end
      end

      if (enter_report) begin
        bus.done_o     <= 1'b1;
        bus.computed_o <= snap;
        bus.received_o <= acc[7:0];
        bus.fmt_err_o  <= rep_bad;
        bus.ok_o       <= !rep_bad && (acc[7:0] == snap);
      end
    end
  end

endmodule

// File: tb/tb_verify_checksum.sv
// Scoreboard bench for verify_checksum: stimulus queues expected verdicts,
// a negedge monitor pops and compares each done pulse.
module tb_verify_checksum;

  typedef struct packed {
    logic       ok;
    logic       fmt_err;
    logic [7:0] computed;
    logic [7:0] received;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  exp_t q[$];

  verify_checksum_if bus ();

  verify_checksum #(.SOH_CHAR(8'h01)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && bus.done_o) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ok",       {31'd0, bus.ok_o},       {31'd0, e.ok});
        chk("fmt_err",  {31'd0, bus.fmt_err_o},  {31'd0, e.fmt_err});
        chk("computed", {24'd0, bus.computed_o}, {24'd0, e.computed});
        chk("received", {24'd0, bus.received_o}, {24'd0, e.received});
      end
    end
  end

  task automatic put(input logic [7:0] b, input bit st, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    bus.data_i  = b;
    bus.start_i = st;
    bus.valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.start_i = 1'b0;
    bus.data_i  = 8'h00;
  endtask

  // '|' in the string stands for SOH (0x01); first byte carries start.
  task automatic send(input string s, input bit gaps, input bit want_done);
    logic [7:0] b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      if (b == 8'h7C) b = 8'h01;
      put(b, i == 0, gaps);
      if (i == 1) chk("busy_mid_msg", {31'd0, bus.busy_o}, 32'd1);
    end
    if (want_done) chk("done_latency", {31'd0, bus.done_o}, 32'd1);
  endtask

  task automatic expect_res(input bit ok, input bit fe, input logic [7:0] c, input logic [7:0] r);
    exp_t e;
    e.ok = ok; e.fmt_err = fe; e.computed = c; e.received = r;
    q.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done"},     {31'd0, bus.done_o},     32'd0);
    chk({tag, "_ok"},       {31'd0, bus.ok_o},       32'd0);
    chk({tag, "_fmt_err"},  {31'd0, bus.fmt_err_o},  32'd0);
    chk({tag, "_computed"}, {24'd0, bus.computed_o}, 32'd0);
    chk({tag, "_received"}, {24'd0, bus.received_o}, 32'd0);
    chk({tag, "_busy"},     {31'd0, bus.busy_o},     32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    bus.data_i = 8'h00;
    bus.valid_i = 1'b0;
    bus.start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Good checksum: 0x38+0x3D+0x41+0x01 = 183
    expect_res(1'b1, 1'b0, 8'd183, 8'd183);
    send("8=A|10=183|", 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("held_computed", {24'd0, bus.computed_o}, 32'd183);
    chk("held_done_low", {31'd0, bus.done_o}, 32'd0);
    chk("idle_not_busy", {31'd0, bus.busy_o}, 32'd0);

    expect_res(1'b0, 1'b0, 8'd183, 8'd184);
    send("8=A|10=184|", 1'b0, 1'b1);

    // 56+61+122+122+1 = 362 -> 106 after wrap
    expect_res(1'b1, 1'b0, 8'd106, 8'd106);
    send("8=zz|10=106|", 1'b0, 1'b1);

    // False trailer "1=B" folds into the body: 183+49+61+66+1 = 360 -> 104
    expect_res(1'b1, 1'b0, 8'd104, 8'd104);
    send("8=A|1=B|10=104|", 1'b0, 1'b1);
    expect_res(1'b1, 1'b0, 8'd104, 8'd104);
    send("8=A|1=B|10=104|", 1'b1, 1'b1);

    // Bad digit: report on the cycle after 'A', acc holds 1
    expect_res(1'b0, 1'b1, 8'd183, 8'd1);
    send("8=A|10=1A", 1'b0, 1'b1);
    @(posedge clk);
    #1;

    // 300 > 255: received shows low byte 44
    expect_res(1'b0, 1'b1, 8'd183, 8'd44);
    send("8=A|10=300|", 1'b0, 1'b1);

    expect_res(1'b0, 1'b1, 8'd183, 8'd183);
    send("8=A|10=183X", 1'b0, 1'b1);
    @(posedge clk);
    #1;

    // start_i mid-trailer aborts silently; the new message reports once
    send("8=A|10=1", 1'b0, 1'b0);
    expect_res(1'b1, 1'b0, 8'd106, 8'd106);
    send("8=zz|10=106|", 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset mid-body discards the message and clears outputs
    send("8=A|1", 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("midreset");
    @(posedge clk);
    #1;
    chk_zero("midreset_hold");
    rst = 1'b1;
    @(posedge clk);
    #1;
    expect_res(1'b1, 1'b0, 8'd183, 8'd183);
    send("8=A|10=183|", 1'b1, 1'b1);

    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    while (q.size() != 0) begin
      void'(q.pop_front());
      chk("missing_done", 32'd0, 32'd1);
    end
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
